fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch stage sitting directly downstream of the program counter and upstream of decode.
- Takes the current PC and issues word requests to instruction memory over a req/gnt + rvalid interface.
- Tags and buffers returned instructions in order, and presents {inst, inst_pc} to decode with a valid/ready handshake.
- Back-pressures the PC via pc_stall, and discards queued and in-flight fetches on a branch flush.

Parameters:
- ADDR_W, 32, width of PC / instruction-memory address.
- DATA_W, 32, instruction word width.
- DEPTH, 4, max outstanding plus buffered fetches (power of 2, >=2).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- pc  in  ADDR_W  fetch address from program counter.
- pc_valid  in  1  pc is a valid fetch address this cycle.
- pc_stall  out  1  PC must hold its value this cycle.
- flush  in  1  branch taken; discard everything older than the next pc.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  ADDR_W  request address (equal to pc).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid (in request order, latency >= 1).
- imem_rdata  in  DATA_W  response instruction.
- inst_valid  out  1  head instruction available to decode.
- inst  out  DATA_W  head instruction.
- inst_pc  out  ADDR_W  PC of head instruction.
- inst_ready  in  1  decode consumes head this cycle.
- resp_err  out  1  sticky flag, set on a protocol violation.

Behaviour:
- Reset (reset=0, asynchronous), all outputs 0:
  - imem_req=0, inst_valid=0, resp_err=0, pc_stall=0.
  - All counters and FIFO pointers cleared.
- Counters:
  - outstanding (0..DEPTH): accepted requests whose response has not yet returned, live or discarded.
  - discard (0..DEPTH): in-flight responses to drop.
  - qcount (0..DEPTH): entries in the instruction buffer.
- Credit: credit = (outstanding + qcount < DEPTH).
- Request generation (combinational): imem_req = pc_valid & credit & ~flush; imem_addr = pc.
- Request acceptance:
  - Accept = imem_req & imem_gnt.
  - On accept, push pc into the tag FIFO and increment outstanding.
- pc_stall = pc_valid & ~(imem_req & imem_gnt). PC advances only on accept.
- Response handling: on imem_rvalid, decrement outstanding.
  - If discard>0: decrement discard and drop the data.
  - Else: pop the tag FIFO and push {tag, imem_rdata} into the instruction buffer.
- Latency:
  - Response in cycle N gives inst_valid=1 in cycle N+1 (registered buffer write).
  - No combinational rvalid-to-inst path.
- Decode handshake:
  - inst_valid = (qcount != 0); inst and inst_pc are driven from the buffer head.
  - Pop when inst_valid & inst_ready.
  - Head data stays stable while inst_valid & ~inst_ready.
- Simultaneous push and pop in one cycle: qcount is unchanged, both take effect.
- Overflow: impossible by credit; credit counts discarded in-flight responses too.
- Flush (a cycle with flush=1):
  - Instruction buffer and tag FIFO are cleared at the next edge; inst_valid=0 the next cycle.
  - discard_next = discard + outstanding - (imem_rvalid ? 1 : 0); the rvalid in the flush cycle is dropped.
  - No request is issued in the flush cycle. Issue resumes the next cycle using the new pc.
  - A pop by decode in the flush cycle is allowed and has no further effect.
- Protocol violation: imem_rvalid with outstanding==0 sets resp_err (cleared only by reset); the data is ignored.
- Wrap-around: FIFO pointers are log2(DEPTH) bits and wrap naturally. Counters are $clog2(DEPTH)+1 bits and saturate never by construction.
- Reset mid-operation: all state is dropped immediately; responses still arriving after reset deassert set resp_err.

Decomposition:
- Shared package fetch_pkg:
  - ADDR_W/DATA_W defaults.
  - Typedef fetch_entry_t = {inst_pc, inst}.
  - Constant RESET_PC, shared with the program counter.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/clear, count, head):
  - Instantiated twice: tag FIFO of ADDR_W, instruction buffer of fetch_entry_t.
- Top level holds the credit, discard and stall logic.

Test Plan:
- Back-to-back, gnt=1, 1-cycle memory latency, inst_ready=1, pc 0,1,2,3:
  - inst_pc 0..3 appear on consecutive cycles, each 2 cycles after its request.
  - pc_stall stays 0.
- inst_ready=0 with DEPTH=4:
  - After 4 accepts, imem_req=0 and pc_stall=1.
  - Raising inst_ready resumes requests one cycle later.
  - Order is preserved: pc 0..3 first.
- 3-cycle latency, flush asserted with 2 requests outstanding (pc 8,9), then pc=40:
  - Responses for 8 and 9 are dropped.
  - First inst_valid carries inst_pc=40.
- flush coincident with imem_rvalid for an outstanding pc 5:
  - That response is dropped and discard=outstanding-1.
  - No entry for pc 5 appears.
- imem_gnt held 0 for 3 cycles with pc_valid=1, pc=12:
  - imem_req=1 and pc_stall=1 all 3 cycles.
  - A single accept on gnt gives exactly one inst_pc=12.
- Spurious imem_rvalid after reset with nothing outstanding:
  - resp_err=1, inst_valid stays 0.
  - Driving reset=0 mid-stream clears resp_err, inst_valid and imem_req asynchronously.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC and the buffered entry layout.
// Also used by the program counter, so RESET_PC lives here rather than in the PC block.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  localparam logic [FETCH_ADDR_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] inst_pc;
    logic [FETCH_DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with clear; registered write, head read combinationally from storage.
// Latency: push visible at head next cycle; no internal backpressure, callers must respect count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != FULL) | do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues PC requests to imem, tags responses in order, hands {inst, inst_pc} to decode.
// Response-to-inst_valid is one cycle; credit on outstanding+buffered throttles requests and stalls the PC.
module fetch_queue import fetch_pkg::*; #(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  output logic              pc_stall,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              resp_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = DEPTH[CNT_W:0];

  logic [CNT_W-1:0]         outstanding;
  logic [CNT_W-1:0]         discard;
  logic [CNT_W-1:0]         qcount;
  logic [CNT_W-1:0]         tag_count;
  logic [ADDR_W-1:0]        tag_head;
  logic [ADDR_W+DATA_W-1:0] buf_head;
  logic                     credit;
  logic                     accept;
  logic                     rsp_ok;
  logic                     rsp_live;
  logic                     inst_pop;

  // Discarded in-flight responses still hold credit until they come back.
  assign credit    = ({1'b0, outstanding} + {1'b0, qcount}) < DEPTH_C;
  assign imem_req  = reset & pc_valid & credit & ~flush;
  assign imem_addr = pc;
  assign accept    = imem_req & imem_gnt;
  assign pc_stall  = reset & pc_valid & ~accept;

  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign rsp_ok    = imem_rvalid & (outstanding != '0);
  assign rsp_live  = rsp_ok & (discard == '0) & (tag_count != '0) & ~flush;

  assign inst_valid = (qcount != '0);
  assign inst_pop   = inst_valid & inst_ready & ~flush;
  assign inst_pc    = buf_head[ADDR_W+DATA_W-1:DATA_W];
  assign inst       = buf_head[DATA_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
      discard     <= '0;
      resp_err    <= 1'b0;
    end else begin
      outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp_ok);
      if (flush)
        discard <= discard + outstanding - CNT_W'(rsp_ok);
      else if (rsp_ok && discard != '0)
        discard <= discard - 1'b1;
      if (imem_rvalid && outstanding == '0)
        resp_err <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (pc),
    .pop       (rsp_live),
    .clear     (flush),
    .count     (tag_count),
    .head      (tag_head)
  );

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_inst_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_live),
    .push_data ({tag_head, imem_rdata}),
    .pop       (inst_pop),
    .clear     (flush),
    .count     (qcount),
    .head      (buf_head)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle stimulus tables with hand-derived outputs, plus a
// fixed-latency in-order instruction memory whose data is the request address XOR a key.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        pc_stall;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  int          lat = 1;
  int          cyc = 0;
  logic        manual = 1'b0;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        mdl_rvalid = 1'b0;
  logic [31:0] mdl_rdata = '0;

  assign imem_rvalid = manual ? man_rvalid : mdl_rvalid;
  assign imem_rdata  = manual ? man_rdata  : mdl_rdata;

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .pc_stall    (pc_stall),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .resp_err    (resp_err)
  );

  // In-order memory: a request accepted in cycle N responds in cycle N+lat.
  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;
  pend_t pend[$];

  always begin
    @(posedge clk);
    if (!reset) pend.delete();
    else if (imem_req && imem_gnt) pend.push_back('{cyc + lat, imem_addr});
    cyc++;
    @(negedge clk);
    mdl_rvalid = 1'b0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      mdl_rvalid = 1'b1;
      mdl_rdata  = pend[0].addr ^ KEY;
      void'(pend.pop_front());
    end
  end

  typedef struct packed {
    logic        pcv;
    logic [31:0] pcv_addr;
    logic        fl;
    logic        gnt;
    logic        rdy;
    logic        req;
    logic        stall;
    logic        iv;
    logic [31:0] ipc;
  } row_t;

  function automatic row_t r(logic pcv, logic [31:0] a, logic fl, logic gnt, logic rdy,
                             logic req, logic stall, logic iv, logic [31:0] ipc);
    return '{pcv, a, fl, gnt, rdy, req, stall, iv, ipc};
  endfunction

  task automatic test_reset();
    pc_valid = 1'b1;
    imem_gnt = 1'b1;
    #2;
    checks++;
    if ({imem_req, pc_stall, inst_valid, resp_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: got req/stall/iv/err=%b want 0000",
               {imem_req, pc_stall, inst_valid, resp_err});
    end
    checks++;
    if ({inst_pc, inst} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {inst_pc, inst});
    end
    @(negedge clk);
    reset    = 1'b1;
    pc_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    row_t t[$];
    lat = 1;
    t.push_back(r(1, 0, 0, 1, 1, 1, 0, 0, 0));
    t.push_back(r(1, 1, 0, 1, 1, 1, 0, 0, 0));
    t.push_back(r(1, 2, 0, 1, 1, 1, 0, 1, 0));
    t.push_back(r(1, 3, 0, 1, 1, 1, 0, 1, 1));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 1, 2));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 1, 3));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 0, 0));
    foreach (t[k]) begin
      @(negedge clk);
      pc_valid = t[k].pcv; pc = t[k].pcv_addr; flush = t[k].fl;
      imem_gnt = t[k].gnt; inst_ready = t[k].rdy;
      #1;
      checks++;
      if ({imem_req, pc_stall, inst_valid} !== {t[k].req, t[k].stall, t[k].iv}) begin
        errors++;
        $display("FAIL b2b_ctl cyc %0d: got req/stall/iv=%b want %b", k,
                 {imem_req, pc_stall, inst_valid}, {t[k].req, t[k].stall, t[k].iv});
      end
      if (t[k].iv) begin
        checks++;
        if ({inst_pc, inst} !== {t[k].ipc, t[k].ipc ^ KEY}) begin
          errors++;
          $display("FAIL b2b_data cyc %0d: got %h want %h", k, {inst_pc, inst},
                   {t[k].ipc, t[k].ipc ^ KEY});
        end
      end
    end
  endtask

  task automatic test_stall_ready();
    row_t t[$];
    lat = 1;
    t.push_back(r(1, 0, 0, 1, 0, 1, 0, 0, 0));
    t.push_back(r(1, 1, 0, 1, 0, 1, 0, 0, 0));
    t.push_back(r(1, 2, 0, 1, 0, 1, 0, 1, 0));
    t.push_back(r(1, 3, 0, 1, 0, 1, 0, 1, 0));
    t.push_back(r(1, 4, 0, 1, 0, 0, 1, 1, 0));
    t.push_back(r(1, 4, 0, 1, 0, 0, 1, 1, 0));
    t.push_back(r(1, 4, 0, 1, 0, 0, 1, 1, 0));
    t.push_back(r(1, 4, 0, 1, 1, 0, 1, 1, 0));
    t.push_back(r(1, 4, 0, 1, 1, 1, 0, 1, 1));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 1, 2));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 1, 3));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 1, 4));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 0, 0));
    foreach (t[k]) begin
      @(negedge clk);
      pc_valid = t[k].pcv; pc = t[k].pcv_addr; flush = t[k].fl;
      imem_gnt = t[k].gnt; inst_ready = t[k].rdy;
      #1;
      checks++;
      if ({imem_req, pc_stall, inst_valid} !== {t[k].req, t[k].stall, t[k].iv}) begin
        errors++;
        $display("FAIL full_ctl cyc %0d: got req/stall/iv=%b want %b", k,
                 {imem_req, pc_stall, inst_valid}, {t[k].req, t[k].stall, t[k].iv});
      end
      if (t[k].iv) begin
        checks++;
        if ({inst_pc, inst} !== {t[k].ipc, t[k].ipc ^ KEY}) begin
          errors++;
          $display("FAIL full_data cyc %0d: got %h want %h", k, {inst_pc, inst},
                   {t[k].ipc, t[k].ipc ^ KEY});
        end
      end
    end
  endtask

  task automatic test_flush_discard();
    row_t t[$];
    lat = 3;
    t.push_back(r(1, 8,  0, 1, 1, 1, 0, 0, 0));
    t.push_back(r(1, 9,  0, 1, 1, 1, 0, 0, 0));
    t.push_back(r(1, 40, 1, 1, 1, 0, 1, 0, 0));
    t.push_back(r(1, 40, 0, 1, 1, 1, 0, 0, 0));
    t.push_back(r(0, 0,  0, 1, 1, 0, 0, 0, 0));
    t.push_back(r(0, 0,  0, 1, 1, 0, 0, 0, 0));
    t.push_back(r(0, 0,  0, 1, 1, 0, 0, 0, 0));
    t.push_back(r(0, 0,  0, 1, 1, 0, 0, 1, 40));
    t.push_back(r(0, 0,  0, 1, 1, 0, 0, 0, 0));
    foreach (t[k]) begin
      @(negedge clk);
      pc_valid = t[k].pcv; pc = t[k].pcv_addr; flush = t[k].fl;
      imem_gnt = t[k].gnt; inst_ready = t[k].rdy;
      #1;
      checks++;
      if ({imem_req, pc_stall, inst_valid} !== {t[k].req, t[k].stall, t[k].iv}) begin
        errors++;
        $display("FAIL flush_ctl cyc %0d: got req/stall/iv=%b want %b", k,
                 {imem_req, pc_stall, inst_valid}, {t[k].req, t[k].stall, t[k].iv});
      end
      if (t[k].iv) begin
        checks++;
        if ({inst_pc, inst} !== {t[k].ipc, t[k].ipc ^ KEY}) begin
          errors++;
          $display("FAIL flush_data cyc %0d: got %h want %h", k, {inst_pc, inst},
                   {t[k].ipc, t[k].ipc ^ KEY});
        end
      end
    end
  endtask

  task automatic test_flush_rvalid();
    row_t t[$];
    lat = 2;
    t.push_back(r(1, 5, 0, 1, 1, 1, 0, 0, 0));
    t.push_back(r(1, 6, 0, 1, 1, 1, 0, 0, 0));
    t.push_back(r(0, 0, 1, 1, 1, 0, 0, 0, 0));
    t.push_back(r(1, 7, 0, 1, 1, 1, 0, 0, 0));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 0, 0));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 0, 0));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 1, 7));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 0, 0));
    foreach (t[k]) begin
      @(negedge clk);
      pc_valid = t[k].pcv; pc = t[k].pcv_addr; flush = t[k].fl;
      imem_gnt = t[k].gnt; inst_ready = t[k].rdy;
      #1;
      checks++;
      if ({imem_req, pc_stall, inst_valid} !== {t[k].req, t[k].stall, t[k].iv}) begin
        errors++;
        $display("FAIL flrv_ctl cyc %0d: got req/stall/iv=%b want %b", k,
                 {imem_req, pc_stall, inst_valid}, {t[k].req, t[k].stall, t[k].iv});
      end
      if (t[k].iv) begin
        checks++;
        if ({inst_pc, inst} !== {t[k].ipc, t[k].ipc ^ KEY}) begin
          errors++;
          $display("FAIL flrv_data cyc %0d: got %h want %h", k, {inst_pc, inst},
                   {t[k].ipc, t[k].ipc ^ KEY});
        end
      end
      // Two outstanding at the flush, one returning in that cycle: one left to drop.
      if (k == 3) begin
        checks++;
        if (dut.discard !== 3'd1) begin
          errors++;
          $display("FAIL flrv_discard: got %0d want 1", dut.discard);
        end
      end
    end
  endtask

  task automatic test_gnt_wait();
    row_t t[$];
    lat = 1;
    t.push_back(r(1, 12, 0, 0, 1, 1, 1, 0, 0));
    t.push_back(r(1, 12, 0, 0, 1, 1, 1, 0, 0));
    t.push_back(r(1, 12, 0, 0, 1, 1, 1, 0, 0));
    t.push_back(r(1, 12, 0, 1, 1, 1, 0, 0, 0));
    t.push_back(r(0, 0,  0, 1, 1, 0, 0, 0, 0));
    t.push_back(r(0, 0,  0, 1, 1, 0, 0, 1, 12));
    t.push_back(r(0, 0,  0, 1, 1, 0, 0, 0, 0));
    foreach (t[k]) begin
      @(negedge clk);
      pc_valid = t[k].pcv; pc = t[k].pcv_addr; flush = t[k].fl;
      imem_gnt = t[k].gnt; inst_ready = t[k].rdy;
      #1;
      checks++;
      if ({imem_req, pc_stall, inst_valid} !== {t[k].req, t[k].stall, t[k].iv}) begin
        errors++;
        $display("FAIL gnt_ctl cyc %0d: got req/stall/iv=%b want %b", k,
                 {imem_req, pc_stall, inst_valid}, {t[k].req, t[k].stall, t[k].iv});
      end
      if (t[k].iv) begin
        checks++;
        if ({inst_pc, inst} !== {t[k].ipc, t[k].ipc ^ KEY}) begin
          errors++;
          $display("FAIL gnt_data cyc %0d: got %h want %h", k, {inst_pc, inst},
                   {t[k].ipc, t[k].ipc ^ KEY});
        end
      end
    end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    reset = 1'b0;
    pc_valid = 1'b0; flush = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    manual = 1'b1; man_rvalid = 1'b1; man_rdata = 32'h1234_5678;
    #1;
    checks++;
    if (resp_err !== 1'b0) begin
      errors++;
      $display("FAIL spur_err_pre: got %b want 0", resp_err);
    end
    @(negedge clk);
    man_rvalid = 1'b0;
    #1;
    checks++;
    if ({resp_err, inst_valid} !== 2'b10) begin
      errors++;
      $display("FAIL spur_err: got err/iv=%b want 10", {resp_err, inst_valid});
    end
    @(negedge clk);
    manual = 1'b0; lat = 1;
    pc_valid = 1'b1; pc = 32'd20;
    @(negedge clk);
    pc_valid = 1'b0;
    @(negedge clk);
    pc_valid = 1'b1; pc = 32'd21; imem_gnt = 1'b0;
    #1;
    checks++;
    if ({resp_err, inst_valid, imem_req, inst_pc} !== {3'b111, 32'd20}) begin
      errors++;
      $display("FAIL spur_live: got err/iv/req=%b pc=%0d want 111 pc=20",
               {resp_err, inst_valid, imem_req}, inst_pc);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({resp_err, inst_valid, imem_req, pc_stall} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got err/iv/req/stall=%b want 0000",
               {resp_err, inst_valid, imem_req, pc_stall});
    end
    @(negedge clk);
    reset = 1'b1;
    pc_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall_ready();
    test_flush_discard();
    test_flush_rvalid();
    test_gnt_wait();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
